// File: rtl/instruction_loader.sv
// Byte-stream loader for the instruction memory: packs four bytes MSB-first into
// a word and writes consecutive words from a programmable base address.
module instruction_loader #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 11
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE_ADDR,
   input  logic [CNT_W-1:0]  WORD_COUNT,
   input  logic              BYTE_VALID,
   input  logic [7:0]        BYTE_DATA,
   output logic              BYTE_READY,
   output logic              WE,
   output logic [ADDR_W-1:0] ADDRESS,
   output logic [31:0]       DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic [7:0]        CHECKSUM
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [23:0]      word;
   logic [1:0]       byte_idx;

   // Only the three most recent bytes are kept; the fourth goes straight to DATA.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state      <= IDLE;
         remaining  <= '0;
         word       <= '0;
         byte_idx   <= '0;
         BYTE_READY <= 1'b0;
         WE         <= 1'b0;
         ADDRESS    <= '0;
         DATA       <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         CHECKSUM   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  ADDRESS   <= BASE_ADDR;
                  remaining <= WORD_COUNT;
                  CHECKSUM  <= '0;
                  byte_idx  <= '0;
                  BUSY      <= 1'b1;
                  if (WORD_COUNT == '0) begin
                     state <= FIN;
                     DONE  <= 1'b1;
                  end else begin
                     state      <= RECV;
                     BYTE_READY <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (BYTE_VALID && BYTE_READY) begin
                  word     <= {word[15:0], BYTE_DATA};
                  CHECKSUM <= CHECKSUM + BYTE_DATA;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     DATA       <= {word, BYTE_DATA};
                     WE         <= 1'b1;
                     BYTE_READY <= 1'b0;
                     state      <= WRITE;
                  end
               end
            end
            WRITE: begin
               WE        <= 1'b0;
               ADDRESS   <= ADDRESS + ADDR_W'(1);
               remaining <= remaining - CNT_W'(1);
               if (remaining == CNT_W'(1)) begin
                  state <= FIN;
                  DONE  <= 1'b1;
               end else begin
                  state      <= RECV;
                  BYTE_READY <= 1'b1;
               end
            end
            FIN: begin
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
